// File: rtl/uart_pkg.sv
// Shared UART frame constants and RX FSM encodings, used by both RX and TX.
// No logic: no latency, no backpressure.
package uart_pkg;
    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef logic [DATA_BITS-1:0] byte_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
endpackage

// File: rtl/uart_rx_if.sv
// Byte output channel of the UART receiver: one-entry valid/ready plus error pulses.
// master drives the byte; slave consumes it and may stall via ready_i.
interface uart_rx_if;
    uart_pkg::byte_t rx_data_o;
    logic            valid_o;
    logic            ready_i;
    logic            frame_err_o;
    logic            overrun_o;

    modport master (output rx_data_o, output valid_o, output frame_err_o,
                    output overrun_o, input ready_i);
    modport slave  (input rx_data_o, input valid_o, input frame_err_o,
                    input overrun_o, output ready_i);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// 1-bit two-flop synchronizer, 2-cycle latency, async reset to RST_VAL.
// No backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver; byte valid 2+HALF+9*CLK_PER_BIT clocks after the first low sample.
// ready_i never stalls reception: a byte arriving while the holder is full is dropped (overrun).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic      clk_i,
    input  logic      reset_i,
    input  logic      rx_i,
    uart_rx_if.master rx_if
);
    localparam int HALF = CLK_PER_BIT / 2;
    localparam int CW   = $clog2(CLK_PER_BIT) + 1;
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic          rx_sync;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    byte_t         shift_reg;

    sync_2ff #(.RST_VAL(IDLE_LVL)) u_sync (
        .clk (clk_i),
        .rst (reset_i),
        .d   (rx_i),
        .q   (rx_sync)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shift_reg         <= '0;
            rx_if.rx_data_o   <= '0;
            rx_if.valid_o     <= 1'b0;
            rx_if.frame_err_o <= 1'b0;
            rx_if.overrun_o   <= 1'b0;
        end else begin
            rx_if.frame_err_o <= 1'b0;
            rx_if.overrun_o   <= 1'b0;
            if (rx_if.valid_o && rx_if.ready_i)
                rx_if.valid_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_sync == START_LVL)
                        state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again at mid-bit is a glitch.
                        state   <= (rx_sync == START_LVL) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        bit_idx            <= bit_idx + BW'(1);
                        if (bit_idx == LAST_BIT)
                            state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_sync == STOP_LVL) begin
                            state <= ST_IDLE;
                            if (!rx_if.valid_o || rx_if.ready_i) begin
                                rx_if.rx_data_o <= shift_reg;
                                rx_if.valid_o   <= 1'b1;
                            end else begin
                                rx_if.overrun_o <= 1'b1;
                            end
                        end else begin
                            rx_if.frame_err_o <= 1'b1;
                            state             <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // Hold off while the line is in break so it cannot look like a new start.
                    cnt <= '0;
                    if (rx_sync == IDLE_LVL)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected events, a negedge monitor pops and checks them.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;   // 154 for CPB=16

    localparam int EV_NONE = 0;
    localparam int EV_BYTE = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;

    typedef struct {
        int kind;
        int data;
        int t;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  sb[$];
    logic pv    = 1'b0;
    logic pacc  = 1'b0;

    uart_rx_if rif ();

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .rx_i    (rx),
        .rx_if   (rif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic got(input int kind, input int data);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, EV_NONE);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_time", cyc, e.t);
            if (kind == EV_BYTE)
                chk("ev_data", data, e.data);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; the next edge is t0.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int kind);
        int t0;
        ev_t e;
        t0 = cyc + 1;
        if (kind != EV_NONE) begin
            e.kind = kind;
            e.data = int'(d);
            e.t    = t0 + LAT;
            sb.push_back(e);
        end
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rif.frame_err_o || rif.overrun_o)
                chk("both_flags", 32'(rif.frame_err_o & rif.overrun_o), 0);
            if (rif.valid_o && (!pv || pacc))
                got(EV_BYTE, int'(rif.rx_data_o));
            if (rif.frame_err_o)
                got(EV_FERR, 0);
            if (rif.overrun_o)
                got(EV_OVR, 0);
        end
        pv   <= rif.valid_o;
        pacc <= rif.valid_o && rif.ready_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] part;
        int t0;
        rif.ready_i = 1'b1;
        #12;
        chk("rst_valid", rif.valid_o, 0);
        chk("rst_data", rif.rx_data_o, 0);
        chk("rst_ferr", rif.frame_err_o, 0);
        chk("rst_ovr", rif.overrun_o, 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // single byte, consumer always ready
        send_frame(8'hA5, 1'b1, EV_BYTE);
        repeat (20) tick();

        // 3-cycle glitch must be ignored, then a real frame
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (40) tick();
        send_frame(8'h3C, 1'b1, EV_BYTE);
        repeat (20) tick();

        // framing error followed by a break
        send_frame(8'hFF, 1'b0, EV_FERR);
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        repeat (30) tick();

        // overrun: second byte dropped while the first is held
        rif.ready_i = 1'b0;
        send_frame(8'h12, 1'b1, EV_BYTE);
        send_frame(8'h34, 1'b1, EV_OVR);
        repeat (10) tick();
        chk("ovr_hold_data", rif.rx_data_o, 8'h12);
        chk("ovr_hold_valid", rif.valid_o, 1);

        // accept on the same edge as the next delivery
        t0 = cyc + 1;
        fork
            send_frame(8'h34, 1'b1, EV_BYTE);
            begin
                while (cyc != t0 + LAT - 1) tick();
                rif.ready_i = 1'b1;
                tick();
                rif.ready_i = 1'b0;
            end
        join
        repeat (10) tick();
        chk("acc_data", rif.rx_data_o, 8'h34);
        chk("acc_valid", rif.valid_o, 1);

        // async reset during data bit 4 with a byte still held
        part = 8'h5A;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            repeat (CPB) tick();
        end
        rx = part[4];
        repeat (8) tick();
        #2 reset = 1'b1;
        #1;
        chk("rst2_valid", rif.valid_o, 0);
        chk("rst2_data", rif.rx_data_o, 0);
        chk("rst2_ferr", rif.frame_err_o, 0);
        chk("rst2_ovr", rif.overrun_o, 0);
        rx = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rif.ready_i = 1'b1;
        repeat (10) tick();
        send_frame(8'h5A, 1'b1, EV_BYTE);
        repeat (30) tick();

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART controller. It oversamples the asynchronous serial line `rx_i` with the system clock and detects and validates the start bit. It then shifts in 8 data bits LSB-first, checks the stop bit, and presents each good byte on a one-entry valid/ready output register. It sits between the pad-side serial input and the byte consumer, and is the counterpart of the UART transmitter: same frame format (1 start, 8 data, 1 stop, no parity) and same `CLK_PER_BIT` timing parameter.

## Interface
- `CLK_PER_BIT`, default 16: system clocks per serial bit. Legal range is ≥ 4. `HALF = CLK_PER_BIT/2`, using integer division.
- `clk_i` input, 1 bit: the single clock, rising edge.
- `reset_i` input, 1 bit: asynchronous, active-high reset.
- `rx_i` input, 1 bit: serial line, idle high, asynchronous to `clk_i`.
- `rx_data_o` output, 8 bits: received byte, stable while `valid_o` is high.
- `valid_o` output, 1 bit: `rx_data_o` holds an unconsumed byte.
- `ready_i` input, 1 bit: consumer accepts the byte when `valid_o && ready_i`.
- `frame_err_o` output, 1 bit: one-cycle pulse when a sampled stop bit is 0.
- `overrun_o` output, 1 bit: one-cycle pulse when a good byte is dropped because the holding register is full.

## Operation
- **Input synchronizer**
  - `rx_i` passes through two flops to produce `rx_sync`. The FSM uses only `rx_sync`.
- **Bit counter**
  - Width `$clog2(CLK_PER_BIT)+1`.
  - Cleared on every state entry and on every bit sample; otherwise it increments each cycle in START, DATA and STOP.
- **FSM states: IDLE, START, DATA, STOP, WAIT_HIGH**
  - IDLE: `rx_sync==0` → START.
  - START: when counter == HALF−1, sample `rx_sync`. If 0 → DATA. If 1, it was a glitch → IDLE, with no flag raised.
  - DATA: when counter == CLK_PER_BIT−1, shift `rx_sync` into `shift_reg[bit_idx]` (LSB first) and increment `bit_idx`. After bit 7 → STOP.
  - STOP: when counter == CLK_PER_BIT−1, sample `rx_sync`.
    - If 1: deliver the byte, then → IDLE.
    - If 0: pulse `frame_err_o`, discard the byte, then → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_sync==1`, then → IDLE. This prevents a break condition from retriggering reception.
- **Delivery** (at the good-stop-bit sample)
  - If `valid_o==0`, or `valid_o && ready_i` in the same cycle: load `rx_data_o <= shift_reg` and set/keep `valid_o=1`. No overrun.
  - Otherwise: keep the old byte, keep `valid_o=1`, and pulse `overrun_o`.
- **Handshake**
  - `valid_o` drops on the edge after `valid_o && ready_i`, unless a new byte is delivered on that same edge.
  - `rx_data_o` never changes while `valid_o=1` and no accept occurs.
  - `ready_i` never affects reception timing.

## Timing
- **Reset values**
  - `valid_o=0`, `rx_data_o=8'h00`, `frame_err_o=0`, `overrun_o=0`.
  - Both sync flops = 1; state = IDLE; counter and `bit_idx` = 0.
- **Reset**
  - Takes effect immediately (asynchronous) and aborts any frame in progress.
  - After release, a line that is already low is treated as a new start bit.
- **Latency**
  - Let t0 be the first edge that samples `rx_i==0`.
  - START is entered at t0+2.
  - The start bit is confirmed at t0+2+HALF.
  - Data bit i is sampled at t0+2+HALF+(i+1)·CLK_PER_BIT.
  - The stop bit is sampled at t0+2+HALF+9·CLK_PER_BIT. `valid_o` or an error flag is high in the cycle after that edge.
  - For CLK_PER_BIT=16 this is t0+154.
- **Back-to-back frames**
  - The FSM is in IDLE 1 cycle after the stop sample, half a bit before the nominal end of the stop bit.
  - A start edge arriving right after the stop bit is therefore always caught.
- `frame_err_o` and `overrun_o` are registered pulses, exactly one cycle wide, and never asserted together.

## Structure
- A shared `uart_pkg` (include file) holds:
  - the RX FSM state encodings;
  - frame constants: `DATA_BITS=8`, start level 0, stop and idle level 1.
- The transmitter uses the same package.
- One natural sub-module: `sync_2ff`, a 1-bit two-flop synchronizer with an async active-high reset value parameter (here 1). It is reusable for other async inputs.
- The FSM, counter, shift register and output register live in `uart_rx`.

## Test plan
- **Single byte:** CLK_PER_BIT=16, drive frame 0xA5 with `ready_i=1` → `valid_o` high at t0+154 for 1 cycle, `rx_data_o=8'hA5`, no flags.
- **Glitch:** `rx_i` low for 3 cycles, then high → no `valid_o`, no `frame_err_o`, FSM back in IDLE; a following 0x3C frame is received correctly.
- **Framing error:** frame 0xFF with stop bit 0, then line held low for 40 cycles, then high → one `frame_err_o` pulse at t0+154, no `valid_o`, no false start while the line stays low.
- **Overrun:** frames 0x12 then 0x34 back-to-back with `ready_i=0` → `rx_data_o` stays 0x12, one `overrun_o` pulse at the second stop sample.
- **Accept on delivery:** `ready_i` asserted exactly on the second stop-sample edge → no overrun, `rx_data_o=8'h34`, `valid_o` stays high.
- **Reset mid-frame:** assert `reset_i` asynchronously during data bit 4 → all outputs return to reset values immediately; the next full 0x5A frame is received correctly.
